// File: rtl/toeplitz_hash.sv
`default_nettype none
// ============================================================================
// Module   : toeplitz_hash
// Summary  : Streaming GF(2) Toeplitz hash y = T*x, one BS-bit word per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module toeplitz_hash #(
    parameter int BS = 64,
    parameter int N  = 256,
    parameter int L  = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  row0,
    input  logic [L-1:0]  col0,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BS-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [L-1:0]  out_hash
);

    localparam int NW  = N / BS;
    localparam int WW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int NWP = 1 << WW;
    localparam int GW  = N + L - 1;
    localparam int SW  = BS + L - 1;

    localparam logic [WW-1:0] c_last_word = WW'(NW - 1);

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [L-1:0]   r_acc;
    logic [WW-1:0]  r_wcnt;
    logic [GW-1:0]  w_g;
    logic [SW-1:0]  w_slices [NWP];
    logic [SW-1:0]  w_gslice;
    logic [L-1:0]   w_contrib;
    logic           w_accept;
    logic           w_unused;

    // col0[0] duplicates the diagonal, which is taken from row0[0].
    assign w_unused = col0[0];

    assign w_g[L-1 +: N] = row0;

    for (genvar t = 1; t < L; t++) begin : g_col
        assign w_g[L-1-t] = col0[t];
    end

    // Word k only ever touches g[k*BS +: BS+L-1]; pad the mux to a power of two.
    for (genvar k = 0; k < NWP; k++) begin : g_slice
        if (k < NW) begin : g_used
            assign w_slices[k] = w_g[k*BS +: SW];
        end else begin : g_pad
            assign w_slices[k] = '0;
        end
    end

    assign w_gslice = w_slices[r_wcnt];

    // Row i pairs in_data[b] with g[k*BS + b - i + L - 1].
    for (genvar i = 0; i < L; i++) begin : g_row
        assign w_contrib[i] = ^(w_gslice[L-1-i +: BS] & in_data);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid && (r_wcnt == c_last_word)) begin
                    w_state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_ACC;
                end
            end
            default: w_state_next = ST_ACC;
        endcase
    end

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_wcnt <= '0;
        end else if (w_accept) begin
            r_acc  <= r_acc ^ w_contrib;
            r_wcnt <= (r_wcnt == c_last_word) ? '0 : r_wcnt + WW'(1);
        end else if (out_valid && out_ready) begin
            r_acc  <= '0;
            r_wcnt <= '0;
        end
    end

    assign out_hash = out_valid ? r_acc : '0;

endmodule
`default_nettype wire

// File: tb/tb_toeplitz_hash.sv
`default_nettype none
// ============================================================================
// Module   : tb_toeplitz_hash
// Summary  : Scoreboard bench for toeplitz_hash against a direct T*x model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toeplitz_hash;

    localparam int BS = 64;
    localparam int N  = 256;
    localparam int L  = 128;
    localparam int NW = N / BS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  row0;
    logic [L-1:0]  col0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BS-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [L-1:0]  out_hash;

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;
    int first_drive_cyc;

    logic [N-1:0] blk_q [$];
    logic [L-1:0] exp_q [$];
    logic [L-1:0] got_q [$];
    int           out_t_q [$];

    toeplitz_hash #(.BS(BS), .N(N), .L(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .row0      (row0),
        .col0      (col0),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hash  (out_hash)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Row-major T: upper triangle from row0, strictly-lower from col0.
    function automatic logic [L-1:0] model(input logic [N-1:0] x);
        logic [L-1:0] y;
        logic         t;
        y = '0;
        for (int i = 0; i < L; i++) begin
            for (int j = 0; j < N; j++) begin
                t = (j >= i) ? row0[j-i] : col0[i-j];
                y[i] = y[i] ^ (t & x[j]);
            end
        end
        return y;
    endfunction

    function automatic logic [N-1:0] rand_block();
        logic [N-1:0] x;
        for (int k = 0; k < N/32; k++) x[k*32 +: 32] = $urandom();
        return x;
    endfunction

    task automatic put_word(input logic [BS-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Streams every block in blk_q, checking each output against the scoreboard.
    task automatic drain(input bit gaps);
        int           budget;
        int           widx;
        bit           have;
        logic [N-1:0] cur;
        logic [L-1:0] exp;
        budget = 300;
        widx   = 0;
        have   = 1'b0;
        cur    = '0;
        first_drive_cyc = -1;
        got_q.delete();
        out_t_q.delete();
        while ((blk_q.size() > 0 || have || exp_q.size() > 0) && budget > 0) begin
            if (out_valid && out_ready) begin
                vec++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_output: got %h, required no output", out_hash);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_hash !== exp) begin
                        errs++;
                        $display("FAIL scoreboard_hash: got %h, required %h", out_hash, exp);
                    end
                end
                got_q.push_back(out_hash);
                out_t_q.push_back(cyc);
            end
            in_valid = 1'b0;
            if (!have && blk_q.size() > 0) begin
                cur  = blk_q.pop_front();
                have = 1'b1;
                widx = 0;
                exp_q.push_back(model(cur));
            end
            if (have && in_ready && !(gaps && ($urandom_range(0, 1) == 0))) begin
                if (widx == 0 && first_drive_cyc < 0) first_drive_cyc = cyc;
                in_valid = 1'b1;
                in_data  = cur[widx*BS +: BS];
                widx++;
                if (widx == NW) have = 1'b0;
            end
            @(posedge clk); #1;
            budget--;
        end
        in_valid = 1'b0;
        if (budget == 0) begin
            vec++;
            errs++;
            $display("FAIL drain_timeout: got %0d pending outputs, required 0", exp_q.size());
            exp_q.delete();
            blk_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        vec++; if (out_hash !== '0) begin errs++; $display("FAIL reset_out_hash: got %h, required 0", out_hash); end
        reset = 1'b0;
    endtask

    task automatic test_zero();
        blk_q.push_back('0);
        drain(1'b0);
        vec++;
        if (got_q.size() != 1 || got_q[0] !== '0) begin
            errs++; $display("FAIL zero_hash: got %0d outputs, required one zero hash", got_q.size());
        end
        vec++;
        if (out_t_q.size() != 1 || out_t_q[0] - first_drive_cyc != NW) begin
            errs++; $display("FAIL zero_latency: got %0d cycles, required %0d", (out_t_q.size() > 0) ? out_t_q[0] - first_drive_cyc : -1, NW);
        end
    endtask

    task automatic test_e0();
        logic [N-1:0] x;
        x = '0;
        x[0] = 1'b1;
        blk_q.push_back(x);
        drain(1'b0);
        vec++;
        if (got_q.size() != 1 || got_q[0][L-1:1] !== col0[L-1:1] || got_q[0][0] !== row0[0]) begin
            errs++; $display("FAIL e0_hash: got %h, required col0 %h with bit0 %b", (got_q.size() > 0) ? got_q[0] : '0, col0, row0[0]);
        end
    endtask

    task automatic test_elast();
        logic [N-1:0] x;
        logic [L-1:0] r;
        x = '0;
        x[N-1] = 1'b1;
        for (int i = 0; i < L; i++) r[i] = row0[N-1-i];
        blk_q.push_back(x);
        drain(1'b0);
        vec++;
        if (got_q.size() != 1 || got_q[0] !== r) begin
            errs++; $display("FAIL elast_hash: got %h, required %h", (got_q.size() > 0) ? got_q[0] : '0, r);
        end
    endtask

    task automatic test_linearity();
        logic [N-1:0] a;
        logic [N-1:0] b;
        a = rand_block();
        b = rand_block();
        blk_q.push_back(a);
        blk_q.push_back(b);
        blk_q.push_back(a ^ b);
        drain(1'b0);
        vec++;
        if (got_q.size() != 3 || got_q[2] !== (got_q[0] ^ got_q[1])) begin
            errs++; $display("FAIL linearity: got %0d outputs, required h(a^b)==h(a)^h(b)", got_q.size());
        end
        vec++;
        if (out_t_q.size() != 3 || out_t_q[1] - out_t_q[0] != NW + 1 || out_t_q[2] - out_t_q[1] != NW + 1) begin
            errs++; $display("FAIL block_period: got %0d outputs, required period %0d", out_t_q.size(), NW + 1);
        end
    endtask

    task automatic test_gaps();
        logic [N-1:0] c;
        logic [L-1:0] h0;
        c = rand_block();
        blk_q.push_back(c);
        drain(1'b0);
        h0 = (got_q.size() > 0) ? got_q[0] : '0;
        blk_q.push_back(c);
        blk_q.push_back(rand_block());
        drain(1'b1);
        vec++;
        if (got_q.size() != 2 || got_q[0] !== h0) begin
            errs++; $display("FAIL gap_hash: got %h, required %h", (got_q.size() > 0) ? got_q[0] : '0, h0);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [L-1:0] ea;
        logic [L-1:0] eb;
        a  = rand_block();
        b  = rand_block();
        ea = model(a);
        eb = model(b);
        out_ready = 1'b0;
        for (int w = 0; w < NW; w++) put_word(a[w*BS +: BS]);
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1;
            in_data  = b[0 +: BS];
            vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_hash !== ea) begin
                errs++; $display("FAIL backpressure_hold: got v=%b r=%b %h, required v=1 r=0 %h", out_valid, in_ready, out_hash, ea);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++; $display("FAIL backpressure_release: got v=%b r=%b, required v=0 r=1", out_valid, in_ready);
        end
        for (int w = 1; w < NW; w++) begin
            @(posedge clk); #1;
            in_data = b[w*BS +: BS];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vec++;
        if (out_valid !== 1'b1 || out_hash !== eb) begin
            errs++; $display("FAIL backpressure_next: got v=%b %h, required v=1 %h", out_valid, out_hash, eb);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] x;
        out_ready = 1'b0;
        for (int w = 0; w < NW; w++) put_word($urandom());
        vec++;
        if (out_valid !== 1'b1) begin errs++; $display("FAIL full_block_valid: got %b, required 1", out_valid); end
        #3 reset = 1'b1;
        #1;
        vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_hash !== '0) begin
            errs++; $display("FAIL async_reset_out: got v=%b r=%b %h, required v=0 r=1 0", out_valid, in_ready, out_hash);
        end
        #2 reset = 1'b0;
        out_ready = 1'b1;
        put_word({$urandom(), $urandom()});
        put_word({$urandom(), $urandom()});
        #3 reset = 1'b1;
        #1;
        vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_hash !== '0) begin
            errs++; $display("FAIL async_reset_mid: got v=%b r=%b %h, required v=0 r=1 0", out_valid, in_ready, out_hash);
        end
        #2 reset = 1'b0;
        x = '0;
        x[0] = 1'b1;
        blk_q.push_back(x);
        drain(1'b0);
        vec++;
        if (got_q.size() != 1 || got_q[0][L-1:1] !== col0[L-1:1] || got_q[0][0] !== row0[0]) begin
            errs++; $display("FAIL reset_residue: got %h, required col0 %h with bit0 %b", (got_q.size() > 0) ? got_q[0] : '0, col0, row0[0]);
        end
    endtask

    initial begin
        for (int k = 0; k < N/32; k++) row0[k*32 +: 32] = $urandom();
        for (int k = 0; k < L/32; k++) col0[k*32 +: 32] = $urandom();
        test_reset();
        test_zero();
        test_e0();
        test_elast();
        test_linearity();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
